// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It decodes the ALU op and selects operand 2 so that EX
// receives operands that are ready to use. It also handles stall, flush and illegal-encoding drops.
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [6:0]         opcode_i,
    input  logic [2:0]         funct3_i,
    input  logic [6:0]         funct7_i,
    input  logic [XLEN-1:0]    RS1data_i,
    input  logic [XLEN-1:0]    RS2data_i,
    input  logic [XLEN-1:0]    imm_i,
    input  logic [RADDR_W-1:0] RS1addr_i,
    input  logic [RADDR_W-1:0] RS2addr_i,
    input  logic [RADDR_W-1:0] RDaddr_i,
    output logic               valid_o,
    output logic [XLEN-1:0]    data1_o,
    output logic [XLEN-1:0]    data2_o,
    output logic [XLEN-1:0]    RS2data_o,
    output logic [2:0]         ALUCtrl_o,
    output logic               RegWrite_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               MemtoReg_o,
    output logic [RADDR_W-1:0] RS1addr_o,
    output logic [RADDR_W-1:0] RS2addr_o,
    output logic [RADDR_W-1:0] RDaddr_o,
    output logic               illegal_o
);

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE= 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_ADDI = 3'b110,
        ALU_SRAI = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    data1;
        logic [XLEN-1:0]    data2;
        logic [XLEN-1:0]    rs2data;
        alu_op_e            op;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic [RADDR_W-1:0] rs1addr;
        logic [RADDR_W-1:0] rs2addr;
        logic [RADDR_W-1:0] rdaddr;
    } ex_t;

    logic    legal, use_imm, reg_write, mem_read, mem_write, mem_to_reg;
    alu_op_e op;
    ex_t     ex, ex_next;
    logic    illegal;

    always_comb begin
        legal      = 1'b0;
        op         = ALU_AND;
        use_imm    = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (opcode_i)
            OPC_R: begin
                reg_write = 1'b1;
                if (funct7_i == 7'b0000000) begin
                    case (funct3_i)
                        3'b111:  begin legal = 1'b1; op = ALU_AND; end
                        3'b100:  begin legal = 1'b1; op = ALU_XOR; end
                        3'b001:  begin legal = 1'b1; op = ALU_SLL; end
                        3'b000:  begin legal = 1'b1; op = ALU_ADD; end
                        default: ;
                    endcase
                end else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) begin
                    legal = 1'b1; op = ALU_SUB;
                end else if (funct7_i == 7'b0000001 && funct3_i == 3'b000) begin
                    legal = 1'b1; op = ALU_MUL;
                end
            end
            OPC_I: begin
                use_imm   = 1'b1;
                reg_write = 1'b1;
                if (funct3_i == 3'b000) begin
                    legal = 1'b1; op = ALU_ADDI;
                end else if (funct3_i == 3'b101 && funct7_i == 7'b0100000) begin
                    legal = 1'b1; op = ALU_SRAI;
                end
            end
            OPC_LOAD: begin
                legal      = (funct3_i == 3'b010);
                op         = ALU_ADD;
                use_imm    = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                legal     = (funct3_i == 3'b010);
                op        = ALU_ADD;
                use_imm   = 1'b1;
                mem_write = 1'b1;
            end
            // Branch already resolved in ID; it only travels down as a side-effect-free SUB.
            OPC_BR: begin
                legal = (funct3_i == 3'b000);
                op    = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_comb begin
        ex_next            = '0;
        ex_next.valid      = 1'b1;
        ex_next.data1      = RS1data_i;
        ex_next.data2      = use_imm ? imm_i : RS2data_i;
        ex_next.rs2data    = RS2data_i;
        ex_next.op         = op;
        ex_next.reg_write  = reg_write && (RDaddr_i != '0);
        ex_next.mem_read   = mem_read;
        ex_next.mem_write  = mem_write;
        ex_next.mem_to_reg = mem_to_reg;
        ex_next.rs1addr    = RS1addr_i;
        ex_next.rs2addr    = RS2addr_i;
        ex_next.rdaddr     = RDaddr_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            ex      <= '0;
            illegal <= 1'b0;
        end else if (stall_i) begin
            illegal <= 1'b0;
        end else if (!valid_i) begin
            ex      <= '0;
            illegal <= 1'b0;
        end else if (!legal) begin
            ex      <= '0;
            illegal <= 1'b1;
        end else begin
            ex      <= ex_next;
            illegal <= 1'b0;
        end
    end

    assign valid_o    = ex.valid;
    assign data1_o    = ex.data1;
    assign data2_o    = ex.data2;
    assign RS2data_o  = ex.rs2data;
    assign ALUCtrl_o  = ex.op;
    assign RegWrite_o = ex.reg_write;
    assign MemRead_o  = ex.mem_read;
    assign MemWrite_o = ex.mem_write;
    assign MemtoReg_o = ex.mem_to_reg;
    assign RS1addr_o  = ex.rs1addr;
    assign RS2addr_o  = ex.rs2addr;
    assign RDaddr_o   = ex.rdaddr;
    assign illegal_o  = illegal;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32 core; directly feeds the EX-stage ALU.
- Captures decoded operands and control from ID.
- Performs the ALU-source mux and the ALU-control encode, so EX receives ready operands and a 3-bit op.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit; flags unsupported encodings.

Parameters:
XLEN, 32, datapath width (operands, immediate)
RADDR_W, 5, register-file address width

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous reset, active-high
stall_i  input  1  hold all registered outputs this cycle
flush_i  input  1  load a bubble this cycle
valid_i  input  1  ID holds a real instruction
opcode_i  input  7  instr[6:0]
funct3_i  input  3  instr[14:12]
funct7_i  input  7  instr[31:25]
RS1data_i  input  XLEN  register-file read data 1
RS2data_i  input  XLEN  register-file read data 2
imm_i  input  XLEN  sign-extended immediate from ID
RS1addr_i / RS2addr_i / RDaddr_i  input  RADDR_W  register indices
valid_o  output  1  EX holds a real instruction
data1_o  output  XLEN  ALU operand 1 (= RS1data)
data2_o  output  XLEN  ALU operand 2 (RS2data or imm)
RS2data_o  output  XLEN  store data to MEM
ALUCtrl_o  output  3  ALU operation
RegWrite_o / MemRead_o / MemWrite_o / MemtoReg_o  output  1  downstream control
RS1addr_o / RS2addr_o / RDaddr_o  output  RADDR_W  forwarding / writeback indices
illegal_o  output  1  one-cycle pulse: unsupported encoding was dropped

Behaviour:
- ALUCtrl encoding: AND=000, XOR=001, SLL=010, ADD=011, SUB=100, MUL=101, ADDI=110, SRAI=111.
- R-type, opcode 0110011, ALU source RS2:
  - funct7 0000000 with funct3 111 -> AND; 100 -> XOR; 001 -> SLL; 000 -> ADD.
  - funct7 0100000, funct3 000 -> SUB.
  - funct7 0000001, funct3 000 -> MUL.
  - All R-type set RegWrite.
- I-type, opcode 0010011, ALU source imm, RegWrite:
  - funct3 000 -> ADDI.
  - funct3 101 with funct7 0100000 -> SRAI; shamt is imm[4:0], passed unmodified.
- lw (0000011, funct3 010): ADD, imm, RegWrite, MemRead, MemtoReg.
- sw (0100011, funct3 010): ADD, imm, MemWrite.
- beq (1100011, funct3 000): SUB, RS2, no write/mem; the branch is resolved in ID, so this is a no-side-effect pass-through.
- Any other combination is illegal.
- Bubble:
  - valid_o=0, data/addr outputs=0, ALUCtrl_o=000, all control=0.
  - Reset loads a bubble; illegal_o=0 after reset.
- Per-edge priority: rst_i > flush_i > stall_i > load.
  - flush_i: bubble loaded regardless of stall_i; illegal_o=0.
  - stall_i (no flush): every output register holds, illegal_o forced 0. A pending illegal pulse never repeats.
  - load with valid_i=0: bubble, illegal_o=0.
  - load with valid_i=1 and illegal encoding: bubble, illegal_o=1 for exactly that cycle.
  - load with valid_i=1 and legal encoding: all fields registered, valid_o=1, illegal_o=0.
- RDaddr_i==0: RegWrite_o registered as 0. Other fields are unaffected.
- Latency: one cycle, inputs at edge N appear at outputs after edge N. No combinational input-to-output paths.
- Reset mid-stall or mid-flush: reset wins; the bubble appears after that edge.

Test Plan:
- Reset: rst_i=1 for 2 cycles, then rst_i=0 with stall_i=1 -> valid_o=0, ALUCtrl_o=000, all control 0 and held.
- sub x3,x1,x2 with RS1=10, RS2=3 -> next cycle ALUCtrl_o=100, data1_o=10, data2_o=3, RegWrite_o=1, RDaddr_o=3. srai x5,x4,4 with imm=4 -> ALUCtrl_o=111, data2_o=4.
- lw x6,8(x1) with RS1=0x100 -> ALUCtrl_o=011, data2_o=8, MemRead_o=MemtoReg_o=RegWrite_o=1. sw with RS2=0xDEAD -> MemWrite_o=1, RegWrite_o=0, RS2data_o=0xDEAD.
- Load mul, then stall_i=1 for 3 cycles while the ID inputs change -> outputs stay at ALUCtrl_o=101 with the original operands. stall_i=1 with flush_i=1 -> bubble.
- opcode 0110011, funct7 0000000, funct3 010 (slt) -> valid_o=0, illegal_o=1 for one cycle. Hold the same input with stall_i=1 -> illegal_o=0.
- add x0,x1,x2 -> valid_o=1, ALUCtrl_o=011, RegWrite_o=0. valid_i=0 -> bubble, illegal_o=0.
